// File: rtl/ring_osc.sv
// Digitally controlled oscillator modelling a tapped ring oscillator: clk_o is a
// registered square wave whose half-period, in clk_i cycles, is set by freq_sel_i.
module ring_osc #(
    parameter int SEL_W     = 4,
    parameter int BASE_HALF = 2,
    parameter int STEP_HALF = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [SEL_W-1:0] freq_sel_i,
    output logic             clk_o
);

    localparam int MAX_CODE = (1 << SEL_W) - 1;
    localparam int MAX_HALF = BASE_HALF + STEP_HALF * MAX_CODE;
    // Counter only has to reach MAX_HALF-1; keep at least one bit for MAX_HALF=1.
    localparam int CNT_W    = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

    localparam logic [CNT_W-1:0] BASE_M1 = CNT_W'(BASE_HALF - 1);
    localparam logic [CNT_W-1:0] STEP    = CNT_W'(STEP_HALF);

    if (BASE_HALF < 1) begin : g_bad_base
        $error("ring_osc: BASE_HALF must be at least 1");
    end
    if (STEP_HALF < 0) begin : g_bad_step
        $error("ring_osc: STEP_HALF must not be negative");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             clk_d;
    logic [SEL_W-1:0] code_below_max;
    logic [CNT_W-1:0] terminal;
    logic             at_terminal;

    // HALF(sel_q)-1, built from the latched code only so no input reaches clk_o
    // combinationally. MAX_CODE - sel_q is simply the bitwise inverse of sel_q.
    always_comb begin
        code_below_max = ~sel_q;
        terminal       = BASE_M1 + STEP * CNT_W'(code_below_max);
        at_terminal    = (cnt == terminal);
    end

    // NOTE: every variable driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt;
        sel_d = sel_q;
        clk_d = clk_o;
        if (!enable_i) begin
            cnt_d = '0;
            sel_d = freq_sel_i;
            clk_d = 1'b0;
        end else if (at_terminal) begin
            // Code is adopted only here, so every phase runs to full length.
            cnt_d = '0;
            sel_d = freq_sel_i;
            clk_d = ~clk_o;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            sel_q <= '0;
            clk_o <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            sel_q <= sel_d;
            clk_o <= clk_d;
        end
    end

endmodule

// File: tb/tb_ring_osc.sv
// Directed bench for ring_osc: reset hold, start latency, code stepping,
// mid-phase code changes, stop/restart and asynchronous reset.
module tb_ring_osc;

    logic       clk_i;
    logic       rst_i;
    logic       enable_i;
    logic [3:0] freq_sel_i;
    logic       clk_o;

    int checks = 0;
    int errors = 0;
    int n;

    ring_osc dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .freq_sel_i (freq_sel_i),
        .clk_o      (clk_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance k rising edges and sample 1 ns after the last one.
    task automatic step(input int k);
        repeat (k) @(posedge clk_i);
        #1;
    endtask

    // Count rising edges until clk_o changes level; bounded so a stuck output
    // shows up as a wrong count rather than a hang.
    task automatic wait_toggle(output int edges);
        logic prev;
        prev  = clk_o;
        edges = 0;
        do begin
            @(posedge clk_i);
            #1;
            edges++;
        end while (clk_o === prev && edges < 64);
    endtask

    initial begin
        rst_i      = 1'b1;
        enable_i   = 1'b0;
        freq_sel_i = 4'd0;

        // 1: reset held while inputs wiggle
        step(2);
        check("rst_hold_a", int'(clk_o), 0);
        enable_i   = 1'b1;
        freq_sel_i = 4'd15;
        step(5);
        check("rst_hold_b", int'(clk_o), 0);
        freq_sel_i = 4'd7;
        step(3);
        enable_i = 1'b0;
        step(3);
        check("rst_hold_c", int'(clk_o), 0);

        // 2: idle 1000 ns, then start at code 0
        rst_i      = 1'b0;
        freq_sel_i = 4'd0;
        step(100);
        check("idle_low", int'(clk_o), 0);
        enable_i = 1'b1;
        wait_toggle(n);
        check("start_latency_sel0", n, 17);
        check("first_rise_level", int'(clk_o), 1);
        wait_toggle(n);
        check("high_phase_sel0", n, 17);
        check("low_after_high", int'(clk_o), 0);
        wait_toggle(n);
        check("low_phase_sel0", n, 17);

        // 3: code steps, each taking effect at the toggle after the change
        freq_sel_i = 4'd1;
        wait_toggle(n);
        check("old_phase_kept_0", n, 17);
        wait_toggle(n);
        check("phase_sel1_a", n, 16);
        freq_sel_i = 4'd2;
        wait_toggle(n);
        check("phase_sel1_b", n, 16);
        wait_toggle(n);
        check("phase_sel2_a", n, 15);
        freq_sel_i = 4'd6;
        wait_toggle(n);
        check("phase_sel2_b", n, 15);
        wait_toggle(n);
        check("phase_sel6_a", n, 11);
        freq_sel_i = 4'd15;
        wait_toggle(n);
        check("phase_sel6_b", n, 11);
        wait_toggle(n);
        check("phase_sel15_a", n, 2);
        wait_toggle(n);
        check("phase_sel15_b", n, 2);

        // 4: two code changes inside one long phase; only the last counts
        freq_sel_i = 4'd0;
        wait_toggle(n);
        check("phase_before_sel0", n, 2);
        freq_sel_i = 4'd2;
        step(5);
        freq_sel_i = 4'd6;
        wait_toggle(n);
        check("sel0_phase_remaining", n, 12);
        wait_toggle(n);
        check("last_code_wins", n, 11);

        // 5: stop in the high phase, then restart at the fastest code
        if (clk_o !== 1'b1) wait_toggle(n);
        check("at_high_before_stop", int'(clk_o), 1);
        step(3);
        check("still_high_mid_phase", int'(clk_o), 1);
        enable_i   = 1'b0;
        freq_sel_i = 4'd15;
        step(1);
        check("stop_forces_low", int'(clk_o), 0);
        step(4);
        check("stopped_stays_low", int'(clk_o), 0);
        enable_i = 1'b1;
        step(1);
        check("restart_edge1_low", int'(clk_o), 0);
        step(1);
        check("restart_edge2_high", int'(clk_o), 1);
        wait_toggle(n);
        check("restart_phase_sel15", n, 2);

        // 6: asynchronous reset in the high phase, away from any clk_i edge
        if (clk_o !== 1'b1) wait_toggle(n);
        #3;
        rst_i      = 1'b1;
        freq_sel_i = 4'd6;
        #1;
        check("async_reset_low", int'(clk_o), 0);
        #2;
        enable_i = 1'b0;
        step(2);
        rst_i = 1'b0;
        step(1);
        enable_i = 1'b1;
        wait_toggle(n);
        check("resume_latency_sel6", n, 11);
        wait_toggle(n);
        check("resume_phase_sel6", n, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
